// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control unit for the 8-bit CPU core. Each instruction passes
// through the phases FETCH -> DECODE -> EXEC -> WB.
//
//  * FETCH reads a 16-bit word from instruction memory over a req/ack
//    handshake. The word is latched into the instruction register (ir) and the
//    program counter advances.
//  * The register-file write strobe is asserted in WB only, so each
//    instruction writes the register file at most once.
//  * A halt request stops the core at the next instruction boundary. An
//    instruction that is already in flight always completes before the halt.
//
// Ports
//  clk, rst       clock; synchronous active-high reset
//  run            level: start or continue execution (checked in IDLE and WB)
//  halt_req       request a stop at the next instruction boundary
//  imem_req       fetch request, held high for the whole FETCH phase
//  imem_addr      fetch address, always equal to pc
//  imem_ack       fetch data valid this cycle (used only in FETCH)
//  imem_rdata     fetched instruction word
//  ir             current instruction, drives the decoder
//  dec_we         decoder write enable for the current instruction
//  rf_we          register-file write strobe (WB only)
//  pc             address of the next fetch
//  state          IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
//  busy           executing (not IDLE and not HALT)
//  halted         sitting in HALT
//  retired        count of instructions completed since reset (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      ir,
  input  logic             dec_we,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              halt_pend_q, halt_pend_d;
  logic              imem_req_q, imem_req_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  // Next-state logic. The status outputs are derived from state_d so that
  // their registered copies track state_q exactly. In particular, imem_req
  // drops in the cycle after the ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (halt_req) halt_pend_d = 1'b1;
        // An ack in the first FETCH cycle is legal (zero-wait memory).
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (halt_req) halt_pend_d = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (halt_req) halt_pend_d = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        // A halt request that arrives in WB itself also counts, so this is
        // the only point where the core can stop.
        if (halt_pend_q || halt_req) begin
          state_d     = S_HALT;
          halt_pend_d = 1'b0;
        end else if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_FETCH);
    busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d   = (state_d == S_HALT);
  end

  // State register. Reset takes priority over everything, which also drops
  // any fetch that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      retired_q   <= '0;
      halt_pend_q <= 1'b0;
      imem_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      halt_pend_q <= halt_pend_d;
      imem_req_q  <= imem_req_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // The write strobe passes the decoder's enable straight through, but only
  // while the core is in WB.
  assign rf_we     = (state_q == S_WB) && dec_we;

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer.
//
// A behavioural model tracks the architectural view of the core. This view
// is an operating mode (idle / fetching / in the body of an instruction /
// halted), a step index within the instruction body, and pc, ir, the retired
// count and the pending-halt flag. A single compare process checks every DUT
// output against this model on each falling edge.
//
// Directed scenarios pin the model with literal expectations. A randomized
// phase then follows.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        dec_we;
  logic        rf_we;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .dec_we     (dec_we),
    .rf_we      (rf_we),
    .pc         (pc),
    .state      (state),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Model modes: 0 idle, 1 fetching, 2 instruction body, 3 halted.
  // The body lasts three cycles; step 2 is the write-back cycle.
  int          m_mode = 0;
  int          m_step = 0;
  logic [7:0]  m_pc = '0;
  logic [15:0] m_ir = '0;
  logic [15:0] m_ret = '0;
  bit          m_hp = 1'b0;
  bit          model_valid = 1'b0;

  // Compare helper: counts one check and reports it if it does not match.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the model one clock, using the inputs that the DUT sees on the
  // same edge.
  always @(posedge clk) begin
    if (rst) begin
      m_mode      <= 0;
      m_step      <= 0;
      m_pc        <= '0;
      m_ir        <= '0;
      m_ret       <= '0;
      m_hp        <= 1'b0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      if (m_mode == 0) begin
        if (run) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (halt_req) m_hp <= 1'b1;
        if (imem_ack) begin
          m_ir   <= imem_rdata;
          m_pc   <= m_pc + 8'd1;
          m_mode <= 2;
          m_step <= 0;
        end
      end else if (m_mode == 2) begin
        if (m_step < 2) begin
          if (halt_req) m_hp <= 1'b1;
          m_step <= m_step + 1;
        end else begin
          m_ret <= m_ret + 16'd1;
          if (m_hp || halt_req) begin
            m_mode <= 3;
            m_hp   <= 1'b0;
          end else if (run) begin
            m_mode <= 1;
          end else begin
            m_mode <= 0;
          end
        end
      end else begin
        if (!run) m_mode <= 0;
      end
    end
  end

  // The single compare process: check every output against the model on
  // each falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      int exp_state;
      bit in_wb;
      exp_state = (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : (m_mode == 2) ? 2 + m_step : 5;
      in_wb     = (m_mode == 2) && (m_step == 2);
      checkOutput("state",     int'(state),     exp_state);
      checkOutput("pc",        int'(pc),        int'(m_pc));
      checkOutput("imem_addr", int'(imem_addr), int'(m_pc));
      checkOutput("ir",        int'(ir),        int'(m_ir));
      checkOutput("retired",   int'(retired),   int'(m_ret));
      checkOutput("imem_req",  int'(imem_req),  int'(m_mode == 1));
      checkOutput("rf_we",     int'(rf_we),     int'(in_wb && dec_we));
      checkOutput("busy",      int'(busy),      int'(m_mode == 1 || m_mode == 2));
      checkOutput("halted",    int'(halted),    int'(m_mode == 3));
    end
  end

  // Drive one cycle of inputs, let the rising edge consume them, then return
  // just after the edge. The inputs stay stable until the next call.
  task automatic applyStimulus(input logic r_rst, input logic r_run, input logic r_halt,
                               input logic r_ack, input logic r_we, input logic [15:0] r_data);
    rst        = r_rst;
    run        = r_run;
    halt_req   = r_halt;
    imem_ack   = r_ack;
    dec_we     = r_we;
    imem_rdata = r_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int guard;
    logic [15:0] ret0;

    rst = 1'b1; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dec_we = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0);
    checkOutput("reset_state",   int'(state),    0);
    checkOutput("reset_pc",      int'(pc),       0);
    checkOutput("reset_ir",      int'(ir),       0);
    checkOutput("reset_req",     int'(imem_req), 0);
    checkOutput("reset_retired", int'(retired),  0);

    // Zero-wait memory: 12 cycles after entering FETCH give 3 retired
    // instructions and 3 rf_we pulses.
    applyStimulus(0, 1, 0, 1, 1, 16'h2100);
    checkOutput("t1_fetch", int'(state), 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 0, 1, 1, (i < 4) ? 16'h4B03 : 16'h0000);
      if (rf_we) pulses++;
    end
    checkOutput("t1_retired", int'(retired), 3);
    checkOutput("t1_pc",      int'(pc),      3);
    checkOutput("t1_pulses",  pulses,        3);

    // Ack delayed by 3 cycles on address 0: req and address are held and ir
    // does not change until the ack.
    applyStimulus(1, 0, 0, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 16'h5A5A);
      checkOutput("t2_req",  int'(imem_req),  1);
      checkOutput("t2_addr", int'(imem_addr), 0);
      checkOutput("t2_ir",   int'(ir),        0);
    end
    applyStimulus(0, 1, 0, 1, 1, 16'h2100);
    checkOutput("t2_ir_loaded", int'(ir), 16'h2100);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    checkOutput("t2_wb", int'(state), 4);

    // A one-cycle halt request while the instruction at address 5 is in
    // DECODE (pc has already moved on to 6).
    guard = 0;
    while (!(state == 3'd2 && pc == 8'd6) && guard < 200) begin
      applyStimulus(0, 1, 0, 1, 1, 16'h1111);
      guard++;
    end
    if (guard >= 200) begin
      n_errors++;
      $display("[TB] FAIL t3_reach: timed out waiting for DECODE at pc 6");
    end
    applyStimulus(0, 1, 1, 1, 1, 16'h0);
    applyStimulus(0, 1, 0, 1, 1, 16'h0);
    checkOutput("t3_wb_rf_we", int'(rf_we), 1);
    ret0 = retired;
    applyStimulus(0, 1, 0, 1, 1, 16'h0);
    checkOutput("t3_halt",    int'(state),    5);
    checkOutput("t3_pc",      int'(pc),       6);
    checkOutput("t3_retired", int'(retired),  int'(ret0 + 16'd1));
    applyStimulus(0, 1, 0, 1, 1, 16'h0);
    applyStimulus(0, 1, 0, 1, 1, 16'h0);
    checkOutput("t3_stay",  int'(state),    5);
    checkOutput("t3_noreq", int'(imem_req), 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0);
    checkOutput("t3_idle", int'(state), 0);

    // pc wrap-around from 8'hFF to 8'h00.
    guard = 0;
    while (!(state == 3'd1 && pc == 8'hFF) && guard < 2000) begin
      applyStimulus(0, 1, 0, 1, 1, 16'h0F0F);
      guard++;
    end
    if (guard >= 2000) begin
      n_errors++;
      $display("[TB] FAIL t4_reach: timed out waiting for fetch at pc FF");
    end
    applyStimulus(0, 1, 0, 1, 1, 16'h0F0F);
    checkOutput("t4_wrap", int'(pc), 0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    checkOutput("t4_fetch", int'(state),     1);
    checkOutput("t4_addr",  int'(imem_addr), 0);

    // Reset wins over an ack that arrives in the same FETCH cycle.
    checkOutput("t5_pre_req", int'(imem_req), 1);
    applyStimulus(1, 1, 0, 1, 1, 16'hBEEF);
    checkOutput("t5_state",   int'(state),    0);
    checkOutput("t5_pc",      int'(pc),       0);
    checkOutput("t5_ir",      int'(ir),       0);
    checkOutput("t5_req",     int'(imem_req), 0);
    checkOutput("t5_retired", int'(retired),  0);
    applyStimulus(0, 0, 0, 1, 1, 16'hBEEF);
    checkOutput("t5_late_ack", int'(ir), 0);

    // dec_we low during WB, plus spurious acks in DECODE and EXEC.
    applyStimulus(0, 1, 0, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 1, 1, 16'h1234);
    applyStimulus(0, 1, 0, 1, 0, 16'hFFFF);
    applyStimulus(0, 1, 0, 1, 0, 16'hEEEE);
    checkOutput("t6_wb",    int'(state), 4);
    checkOutput("t6_ir",    int'(ir),    16'h1234);
    checkOutput("t6_pc",    int'(pc),    1);
    checkOutput("t6_rf_we", int'(rf_we), 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0);
    checkOutput("t6_retired", int'(retired), 1);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1),
                    16'($urandom));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
